// File: rtl/stream_min_max.sv
// stream_min_max: streaming min/max reducer over in_last-delimited frames.
// A valid/ready sample stream is folded into one registered result per frame
// (minimum, maximum, sample count). Compare is unsigned or two's-complement
// depending on the SIGNED parameter.
// Optional feature macro: MINMAX_IDX_EN adds out_min_idx/out_max_idx, the
// 0-based positions of the samples that set the held minimum and maximum.
// A frame is closed either by in_last or when it reaches 2**CNT_W-1 samples.

module stream_min_max #(
    parameter int DATA   = 8,
    parameter int CNT_W  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATA-1:0]  in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATA-1:0]  out_min,
    output logic [DATA-1:0]  out_max,
    output logic [CNT_W-1:0] out_count
`ifdef MINMAX_IDX_EN
    ,
    output logic [CNT_W-1:0] out_min_idx,
    output logic [CNT_W-1:0] out_max_idx
`endif
);

    // Largest count a frame may reach; the sample that brings it here closes the frame.
    localparam logic [CNT_W-1:0] CNT_LAST = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACC   = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Strict less-than in the configured number representation.
    function automatic logic less_f(input logic [DATA-1:0] a, input logic [DATA-1:0] b);
        logic lt;
        if (SIGNED) begin
            lt = ($signed(a) < $signed(b));
        end else begin
            lt = (a < b);
        end
        return lt;
    endfunction

    state_t            state_r;
    logic [DATA-1:0]   run_min_r;
    logic [DATA-1:0]   run_max_r;
    logic [CNT_W-1:0]  cnt_r;

    logic              accept_s;
    logic              start_s;
    logic              close_s;
    logic              min_take_s;
    logic              max_take_s;
    logic [DATA-1:0]   min_next_s;
    logic [DATA-1:0]   max_next_s;
    logic [CNT_W-1:0]  cnt_next_s;

    // A pending result blocks input only while downstream is not taking it,
    // so a new frame can start in the same cycle the old result leaves.
    assign in_ready = (state_r != HOLD) | out_ready;
    assign accept_s = in_valid & in_ready;
    // EMPTY and HOLD both mean "the next accepted sample opens a new frame".
    assign start_s  = (state_r != ACC);
    assign close_s  = in_last | (cnt_next_s == CNT_LAST);

    // Running min/max/count as they would be after accepting in_data this cycle.
    always_comb begin
        min_take_s = 1'b0;
        max_take_s = 1'b0;
        min_next_s = run_min_r;
        max_next_s = run_max_r;
        cnt_next_s = cnt_r + CNT_W'(1);
        if (start_s) begin
            min_take_s = 1'b1;
            max_take_s = 1'b1;
            min_next_s = in_data;
            max_next_s = in_data;
            cnt_next_s = CNT_W'(1);
        end else begin
            // Strict compares: an equal value keeps the earlier sample.
            min_take_s = less_f(in_data, run_min_r);
            max_take_s = less_f(run_max_r, in_data);
            if (min_take_s) begin
                min_next_s = in_data;
            end else begin
                min_next_s = run_min_r;
            end
            if (max_take_s) begin
                max_next_s = in_data;
            end else begin
                max_next_s = run_max_r;
            end
        end
    end

`ifdef MINMAX_IDX_EN
    logic [CNT_W-1:0] min_idx_r;
    logic [CNT_W-1:0] max_idx_r;
    logic [CNT_W-1:0] pos_s;
    logic [CNT_W-1:0] min_idx_next_s;
    logic [CNT_W-1:0] max_idx_next_s;

    // Position of the incoming sample and the resulting index of min/max.
    always_comb begin
        pos_s          = start_s ? {CNT_W{1'b0}} : cnt_r;
        min_idx_next_s = min_idx_r;
        max_idx_next_s = max_idx_r;
        if (min_take_s) begin
            min_idx_next_s = pos_s;
        end else begin
            min_idx_next_s = min_idx_r;
        end
        if (max_take_s) begin
            max_idx_next_s = pos_s;
        end else begin
            max_idx_next_s = max_idx_r;
        end
    end

    // Index tracking registers, published together with out_min/out_max.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_idx_r   <= {CNT_W{1'b0}};
            max_idx_r   <= {CNT_W{1'b0}};
            out_min_idx <= {CNT_W{1'b0}};
            out_max_idx <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            min_idx_r <= min_idx_next_s;
            max_idx_r <= max_idx_next_s;
            if (close_s) begin
                out_min_idx <= min_idx_next_s;
                out_max_idx <= max_idx_next_s;
            end else begin
                out_min_idx <= out_min_idx;
                out_max_idx <= out_max_idx;
            end
        end else begin
            min_idx_r   <= min_idx_r;
            max_idx_r   <= max_idx_r;
            out_min_idx <= out_min_idx;
            out_max_idx <= out_max_idx;
        end
    end
`else
    // Index tracking not built: no index ports and no index registers.
`endif

    // Frame FSM (EMPTY/ACC/HOLD) with running accumulators and registered result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= EMPTY;
            run_min_r <= {DATA{1'b0}};
            run_max_r <= {DATA{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            out_valid <= 1'b0;
            out_min   <= {DATA{1'b0}};
            out_max   <= {DATA{1'b0}};
            out_count <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            run_min_r <= min_next_s;
            run_max_r <= max_next_s;
            cnt_r     <= cnt_next_s;
            if (close_s) begin
                state_r   <= HOLD;
                out_valid <= 1'b1;
                out_min   <= min_next_s;
                out_max   <= max_next_s;
                out_count <= cnt_next_s;
            end else begin
                // Any previous result has just been handed off (or there was none).
                state_r   <= ACC;
                out_valid <= 1'b0;
            end
        end else if ((state_r == HOLD) && out_ready) begin
            state_r   <= EMPTY;
            out_valid <= 1'b0;
        end else begin
            state_r   <= state_r;
            out_valid <= out_valid;
        end
    end

endmodule

// File: tb/tb_stream_min_max.sv
// Scoreboard bench for stream_min_max. Two instances share the input bus:
// dut_a (unsigned, CNT_W=3, exercises forced close) and dut_b (signed, CNT_W=8).
// Expected results are pushed per frame; negedge monitors pop and compare.

module tb_stream_min_max;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid_a = 1'b0;
    logic       in_valid_b = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    logic       in_ready_a, out_valid_a;
    logic [7:0] out_min_a, out_max_a;
    logic [2:0] out_count_a;
    logic       in_ready_b, out_valid_b;
    logic [7:0] out_min_b, out_max_b;
    logic [7:0] out_count_b;
`ifdef MINMAX_IDX_EN
    logic [2:0] out_min_idx_a, out_max_idx_a;
    logic [7:0] out_min_idx_b, out_max_idx_b;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct {
        int mn;
        int mx;
        int cnt;
        int mni;
        int mxi;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    stream_min_max #(.DATA(8), .CNT_W(3), .SIGNED(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_a), .out_ready(out_ready),
        .out_min(out_min_a), .out_max(out_max_a), .out_count(out_count_a)
`ifdef MINMAX_IDX_EN
        , .out_min_idx(out_min_idx_a), .out_max_idx(out_max_idx_a)
`endif
    );

    stream_min_max #(.DATA(8), .CNT_W(8), .SIGNED(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid_b), .out_ready(out_ready),
        .out_min(out_min_b), .out_max(out_max_b), .out_count(out_count_b)
`ifdef MINMAX_IDX_EN
        , .out_min_idx(out_min_idx_b), .out_max_idx(out_max_idx_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(input int mn, input int mx, input int cnt, input int mni, input int mxi);
        exp_t e;
        e.mn = mn; e.mx = mx; e.cnt = cnt; e.mni = mni; e.mxi = mxi;
        return e;
    endfunction

    // Present one sample to the selected instances and hold it until accepted.
    // Called at posedge+1; returns at posedge+1 after acceptance, valid left high.
    task automatic send(input logic [1:0] sel, input logic [7:0] d, input logic l);
        int waited;
        in_valid_a = sel[0];
        in_valid_b = sel[1];
        in_data    = d;
        in_last    = l;
        waited     = 0;
        forever begin
            @(negedge clk);
            if ((!sel[0] || in_ready_a) && (!sel[1] || in_ready_b)) break;
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        in_last    = 1'b0;
    endtask

    // Monitor for the unsigned instance: compare every result that is handed off.
    always @(negedge clk) begin
        if (!rst && out_valid_a && out_ready) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_result", 1, 0);
            end else begin
                ea = qa.pop_front();
                chk("a_min", int'(out_min_a), ea.mn);
                chk("a_max", int'(out_max_a), ea.mx);
                chk("a_count", int'(out_count_a), ea.cnt);
`ifdef MINMAX_IDX_EN
                chk("a_min_idx", int'(out_min_idx_a), ea.mni);
                chk("a_max_idx", int'(out_max_idx_a), ea.mxi);
`endif
            end
        end
    end

    // Monitor for the signed instance.
    always @(negedge clk) begin
        if (!rst && out_valid_b && out_ready) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_result", 1, 0);
            end else begin
                eb = qb.pop_front();
                chk("b_min", int'(out_min_b), eb.mn);
                chk("b_max", int'(out_max_b), eb.mx);
                chk("b_count", int'(out_count_b), eb.cnt);
`ifdef MINMAX_IDX_EN
                chk("b_min_idx", int'(out_min_idx_b), eb.mni);
                chk("b_max_idx", int'(out_max_idx_b), eb.mxi);
`endif
            end
        end
    end

    initial begin
        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid_a), 0);
        chk("rst_in_ready", int'(in_ready_a), 1);
        chk("rst_out_min", int'(out_min_a), 0);
        chk("rst_out_max", int'(out_max_a), 0);
        chk("rst_out_count", int'(out_count_a), 0);
        @(posedge clk);
        #1;

        // Test 1: 5,3,9,3(last); tie on 3 keeps index 1; result next cycle.
        qa.push_back(mk(3, 9, 4, 1, 2));
        send(2'b01, 8'd5, 1'b0);
        send(2'b01, 8'd3, 1'b0);
        send(2'b01, 8'd9, 1'b0);
        send(2'b01, 8'd3, 1'b1);
        chk("t1_latency_valid", int'(out_valid_a), 1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Test 2: 0x7F,0x80,0x00 on both instances.
        qa.push_back(mk(8'h00, 8'h80, 3, 2, 1));
        qb.push_back(mk(8'h80, 8'h7F, 3, 1, 0));
        send(2'b11, 8'h7F, 1'b0);
        send(2'b11, 8'h80, 1'b0);
        send(2'b11, 8'h00, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Test 3: result held for 5 cycles with out_ready low, then released
        // together with a new single-sample frame.
        out_ready = 1'b0;
        qa.push_back(mk(2, 8, 2, 1, 0));
        qa.push_back(mk(4, 4, 1, 0, 0));
        send(2'b01, 8'd8, 1'b0);
        send(2'b01, 8'd2, 1'b1);
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_stall_in_ready", int'(in_ready_a), 0);
            chk("t3_stall_out_valid", int'(out_valid_a), 1);
            chk("t3_stall_min", int'(out_min_a), 2);
            chk("t3_stall_max", int'(out_max_a), 8);
            chk("t3_stall_count", int'(out_count_a), 2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(2'b01, 8'd4, 1'b1);
        chk("t3_new_valid", int'(out_valid_a), 1);
        chk("t3_new_min", int'(out_min_a), 4);
        chk("t3_new_count", int'(out_count_a), 1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Test 4: CNT_W=3 forces a close after 7 samples; ties on 40 and 70.
        qa.push_back(mk(30, 70, 7, 5, 4));
        qa.push_back(mk(5, 90, 3, 1, 0));
        send(2'b01, 8'd50, 1'b0);
        send(2'b01, 8'd40, 1'b0);
        send(2'b01, 8'd60, 1'b0);
        send(2'b01, 8'd40, 1'b0);
        send(2'b01, 8'd70, 1'b0);
        send(2'b01, 8'd30, 1'b0);
        send(2'b01, 8'd70, 1'b0);
        chk("t4_forced_close_valid", int'(out_valid_a), 1);
        send(2'b01, 8'd90, 1'b0);
        send(2'b01, 8'd5, 1'b0);
        send(2'b01, 8'd90, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Test 5: reset mid-frame discards the partial frame.
        send(2'b01, 8'd11, 1'b0);
        send(2'b01, 8'd12, 1'b0);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("t5_out_valid", int'(out_valid_a), 0);
        chk("t5_out_min", int'(out_min_a), 0);
        chk("t5_out_max", int'(out_max_a), 0);
        chk("t5_out_count", int'(out_count_a), 0);
        chk("t5_in_ready", int'(in_ready_a), 1);
        qa.push_back(mk(6, 6, 1, 0, 0));
        send(2'b01, 8'd6, 1'b1);
        idle();
        repeat (2) @(posedge clk);
        #1;

        // Test 6: back-to-back single-sample frames, one result per cycle.
        qa.push_back(mk(1, 1, 1, 0, 0));
        qa.push_back(mk(2, 2, 1, 0, 0));
        qa.push_back(mk(3, 3, 1, 0, 0));
        for (int i = 1; i <= 3; i++) begin
            send(2'b01, 8'(i), 1'b1);
            chk("t6_valid", int'(out_valid_a), 1);
            chk("t6_min", int'(out_min_a), i);
        end
        idle();
        @(posedge clk);
        #1;
        chk("t6_drain_valid", int'(out_valid_a), 0);

        repeat (3) @(posedge clk);
        #1;
        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
